xmem_loader: RTL

- Upstream feeder for the activation/weight SRAM write path of the core.
- Accepts a valid/ready stream of row-wide input words and converts it into a burst of SRAM write strobes, using consecutive addresses from a programmed base.
- Drives the xmem address/enable fields of the instruction word (inst[19] CEN, inst[18] WEN, inst[17:7] address), plus D_xmem and xw_mode, at the core top level.
- A grant input lets the execution controller take the xmem bus; while grant is low, the loader stalls.

---
 rtl/xmem_loader_if.sv | 33 +++
 rtl/xmem_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/xmem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : xmem_loader_if
// Brief    : Input stream and xmem write-bus signals of the xmem loader.
// Revision : 1.0
// ============================================================================
interface xmem_loader_if #(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int addr_w = 11
) ();
  logic [row*bw-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              grant;
  logic              CEN_xmem;
  logic              WEN_xmem;
  logic [addr_w-1:0] A_xmem;
  logic [row*bw-1:0] D_xmem;
  logic              xw_mode;

  // master: the loader itself; slave: the stream source and SRAM/bus side
  modport master (
    input  in_data, in_valid, grant,
    output in_ready, CEN_xmem, WEN_xmem, A_xmem, D_xmem, xw_mode
  );

  modport slave (
    output in_data, in_valid, grant,
    input  in_ready, CEN_xmem, WEN_xmem, A_xmem, D_xmem, xw_mode
  );
endinterface
`default_nettype wire

// File: rtl/xmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : xmem_loader
// Brief    : Turns a valid/ready word stream into a burst of xmem SRAM writes
//            at consecutive addresses from a programmed base.
// Revision : 1.0
// ============================================================================
module xmem_loader #(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              xw_sel,
  input  logic [addr_w-1:0] base_addr,
  input  logic [addr_w:0]   len,
  xmem_loader_if.master     bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [addr_w:0]   remaining_q, remaining_d;
  logic [addr_w-1:0] addr_q, addr_d;
  logic [addr_w-1:0] a_q, a_d;
  logic [row*bw-1:0] data_q, data_d;
  logic              strobe_q, strobe_d;
  logic              xw_mode_q, xw_mode_d;
  logic              in_ready;
  logic              accept;

  assign in_ready = (state_q == S_LOAD) & bus.grant & (remaining_q != '0);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    a_d         = a_q;
    data_d      = data_q;
    strobe_d    = 1'b0;
    xw_mode_d   = xw_mode_q;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          xw_mode_d   = xw_sel;
          addr_d      = base_addr;
          remaining_d = len;
          state_d     = (len == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          strobe_d    = 1'b1;
          a_d         = addr_q;
          data_d      = bus.in_data;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{addr_w{1'b0}}, 1'b1}) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        // Hold off done until the final write strobe has left the bus.
        if (!strobe_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      a_q         <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      xw_mode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      a_q         <= a_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      xw_mode_q   <= xw_mode_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.CEN_xmem = ~strobe_q;
  assign bus.WEN_xmem = ~strobe_q;
  assign bus.A_xmem   = a_q;
  assign bus.D_xmem   = data_q;
  assign bus.xw_mode  = xw_mode_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
